// File: rtl/maquina_estados_param_if.sv
// Bus between the FIFO-bank supervisor and the main control FSM.
// The master drives requests and FIFO flags; the slave (the FSM) returns state and thresholds.
interface maquina_estados_param_if #(
    parameter int N_FIFOS  = 8,
    parameter int UMBRAL_W = 8
);
    logic                init;
    logic [UMBRAL_W-1:0] bajo;
    logic [UMBRAL_W-1:0] alto;
    logic [N_FIFOS-1:0]  empty_fifos;
    logic [N_FIFOS-1:0]  error_fifos;
    logic [2:0]          estado_actual;
    logic [2:0]          sig_estado;
    logic [UMBRAL_W-1:0] bajo_out;
    logic [UMBRAL_W-1:0] alto_out;
    logic                active_out;
    logic                idle_out;
    logic                error_out;
    logic                cfg_err;
    logic [N_FIFOS-1:0]  error_id;

    modport master (
        output init, bajo, alto, empty_fifos, error_fifos,
        input  estado_actual, sig_estado, bajo_out, alto_out,
               active_out, idle_out, error_out, cfg_err, error_id
    );

    modport slave (
        input  init, bajo, alto, empty_fifos, error_fifos,
        output estado_actual, sig_estado, bajo_out, alto_out,
               active_out, idle_out, error_out, cfg_err, error_id
    );
endinterface

// File: rtl/maquina_estados_param.sv
// Parametrised main control FSM for the FIFO bank: threshold capture with validation,
// sticky ERROR state with captured error mask, and ACTIVE->IDLE hysteresis.
module maquina_estados_param #(
    parameter int N_FIFOS  = 8,
    parameter int UMBRAL_W = 8,
    parameter int BAJO_DEF = 1,
    parameter int ALTO_DEF = 6,
    parameter int IDLE_DLY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    maquina_estados_param_if.slave  bus
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } estado_t;

    localparam int              CNT_W    = $clog2(IDLE_DLY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_DLY - 1);

    estado_t             r_estado;
    logic [CNT_W-1:0]    r_cnt;
    logic [UMBRAL_W-1:0] r_bajo;
    logic [UMBRAL_W-1:0] r_alto;
    logic                r_cfg_err;
    logic [N_FIFOS-1:0]  r_error_id;
    logic                r_idle;
    logic                r_active;
    logic                r_error;

    estado_t             w_sig;
    logic                w_all_empty;
    logic                w_any_err;
    logic [CNT_W-1:0]    w_cnt_nxt;

    assign w_all_empty = &bus.empty_fifos;
    assign w_any_err   = |bus.error_fifos;

    always_comb begin
        w_sig = S_RESET;
        if (reset) begin
            case (r_estado)
                S_RESET:  w_sig = S_INIT;
                S_ERROR:  w_sig = S_ERROR;
                S_INIT: begin
                    if (w_any_err)     w_sig = S_ERROR;
                    else if (bus.init) w_sig = S_INIT;
                    else               w_sig = S_IDLE;
                end
                S_IDLE: begin
                    if (w_any_err)         w_sig = S_ERROR;
                    else if (bus.init)     w_sig = S_INIT;
                    else if (!w_all_empty) w_sig = S_ACTIVE;
                    else                   w_sig = S_IDLE;
                end
                S_ACTIVE: begin
                    if (w_any_err)                             w_sig = S_ERROR;
                    else if (bus.init)                         w_sig = S_INIT;
                    else if (w_all_empty && r_cnt == CNT_LAST) w_sig = S_IDLE;
                    else                                       w_sig = S_ACTIVE;
                end
                default:  w_sig = S_RESET;
            endcase
        end
    end

    // Counter only survives while staying in ACTIVE on all-empty samples
    always_comb begin
        w_cnt_nxt = '0;
        if (r_estado == S_ACTIVE && w_sig == S_ACTIVE && w_all_empty)
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado   <= S_RESET;
            r_cnt      <= '0;
            r_bajo     <= UMBRAL_W'(BAJO_DEF);
            r_alto     <= UMBRAL_W'(ALTO_DEF);
            r_cfg_err  <= 1'b0;
            r_error_id <= '0;
            r_idle     <= 1'b0;
            r_active   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_estado <= w_sig;
            r_cnt    <= w_cnt_nxt;
            if (r_estado == S_INIT) begin
                if (bus.bajo < bus.alto) begin
                    r_bajo    <= bus.bajo;
                    r_alto    <= bus.alto;
                    r_cfg_err <= 1'b0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else begin
                r_cfg_err <= 1'b0;
            end
            if (r_estado != S_ERROR && w_sig == S_ERROR)
                r_error_id <= bus.error_fifos;
            r_idle   <= (w_sig == S_IDLE);
            r_active <= (w_sig == S_ACTIVE);
            r_error  <= (w_sig == S_ERROR);
        end
    end

    assign bus.estado_actual = r_estado;
    assign bus.sig_estado    = w_sig;
    assign bus.bajo_out      = r_bajo;
    assign bus.alto_out      = r_alto;
    assign bus.cfg_err       = r_cfg_err;
    assign bus.error_id      = r_error_id;
    assign bus.idle_out      = r_idle;
    assign bus.active_out    = r_active;
    assign bus.error_out     = r_error;
endmodule

// File: tb/tb_maquina_estados_param.sv
// Directed bench for maquina_estados_param with hand-computed expectations.
module tb_maquina_estados_param;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    maquina_estados_param_if #(.N_FIFOS(8), .UMBRAL_W(8)) bus ();

    maquina_estados_param #(
        .N_FIFOS(8), .UMBRAL_W(8), .BAJO_DEF(1), .ALTO_DEF(6), .IDLE_DLY(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] st,
                             input logic idl, input logic act, input logic err);
        chk({tag, "_estado"}, 32'(bus.estado_actual), 32'(st));
        chk({tag, "_idle"},   32'(bus.idle_out),      32'(idl));
        chk({tag, "_active"}, 32'(bus.active_out),    32'(act));
        chk({tag, "_error"},  32'(bus.error_out),     32'(err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_state(tag, 3'd0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_sig"},  32'(bus.sig_estado), 32'd0);
        chk({tag, "_bajo"}, 32'(bus.bajo_out),   32'd1);
        chk({tag, "_alto"}, 32'(bus.alto_out),   32'd6);
        chk({tag, "_cfg"},  32'(bus.cfg_err),    32'd0);
        chk({tag, "_eid"},  32'(bus.error_id),   32'd0);
    endtask

    initial begin
        bus.init        = 1'b0;
        bus.bajo        = 8'd0;
        bus.alto        = 8'd0;
        bus.empty_fifos = 8'hFF;
        bus.error_fifos = 8'h00;

        // 1: reset held
        #22;
        chk_reset_vals("rst");
        bus.init = 1'b1; bus.bajo = 8'd3; bus.alto = 8'd5;
        reset = 1'b1;
        #1;
        chk("rel_sig", 32'(bus.sig_estado), 32'd1);
        step();
        chk_state("rel", 3'd1, 1'b0, 1'b0, 1'b0);
        chk("rel_bajo_uncaptured", 32'(bus.bajo_out), 32'd1);

        // 2: capture 3/5, then go idle
        step();
        chk("cap_bajo", 32'(bus.bajo_out), 32'd3);
        chk("cap_alto", 32'(bus.alto_out), 32'd5);
        chk("cap_cfg",  32'(bus.cfg_err),  32'd0);
        chk("cap_sig",  32'(bus.sig_estado), 32'd1);
        bus.init = 1'b0;
        #1;
        chk("to_idle_sig", 32'(bus.sig_estado), 32'd2);
        step();
        chk_state("idle1", 3'd2, 1'b1, 1'b0, 1'b0);

        // 3: rejected configurations, then boundary accept
        bus.init = 1'b1; bus.bajo = 8'd5; bus.alto = 8'd5;
        step();
        chk_state("reinit", 3'd1, 1'b0, 1'b0, 1'b0);
        chk("reinit_cfg", 32'(bus.cfg_err), 32'd0);
        step();
        chk("eq_cfg",  32'(bus.cfg_err),  32'd1);
        chk("eq_bajo", 32'(bus.bajo_out), 32'd3);
        chk("eq_alto", 32'(bus.alto_out), 32'd5);
        bus.bajo = 8'd9; bus.alto = 8'd4;
        step();
        chk("inv_cfg",  32'(bus.cfg_err),  32'd1);
        chk("inv_bajo", 32'(bus.bajo_out), 32'd3);
        chk("inv_alto", 32'(bus.alto_out), 32'd5);
        bus.bajo = 8'd0; bus.alto = 8'hFF;
        step();
        chk("max_cfg",  32'(bus.cfg_err),  32'd0);
        chk("max_bajo", 32'(bus.bajo_out), 32'd0);
        chk("max_alto", 32'(bus.alto_out), 32'hFF);
        bus.init = 1'b0; bus.bajo = 8'd9; bus.alto = 8'd4;
        step();
        chk_state("idle2", 3'd2, 1'b1, 1'b0, 1'b0);
        chk("exit_cfg",  32'(bus.cfg_err),  32'd1);
        chk("exit_bajo", 32'(bus.bajo_out), 32'd0);
        step();
        chk("idle_cfg_clr", 32'(bus.cfg_err), 32'd0);
        chk("idle_alto",    32'(bus.alto_out), 32'hFF);

        // 4: hysteresis
        bus.empty_fifos = 8'hFF;
        step();
        chk_state("idle_empty", 3'd2, 1'b1, 1'b0, 1'b0);
        bus.empty_fifos = 8'hFB;
        #1;
        chk("to_act_sig", 32'(bus.sig_estado), 32'd3);
        step();
        chk_state("act", 3'd3, 1'b0, 1'b1, 1'b0);
        bus.empty_fifos = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("act_ff", 3'd3, 1'b0, 1'b1, 1'b0);
        end
        bus.empty_fifos = 8'hFE;
        step();
        chk_state("act_fe", 3'd3, 1'b0, 1'b1, 1'b0);
        bus.empty_fifos = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("act_ff2", 3'd3, 1'b0, 1'b1, 1'b0);
        end
        chk("hyst_sig", 32'(bus.sig_estado), 32'd2);
        step();
        chk_state("hyst_idle", 3'd2, 1'b1, 1'b0, 1'b0);

        // 6: async reset mid-ACTIVE with counter at 2
        bus.empty_fifos = 8'hFB;
        step();
        chk_state("act2", 3'd3, 1'b0, 1'b1, 1'b0);
        bus.empty_fifos = 8'hFF;
        step();
        step();
        chk_state("act2_cnt2", 3'd3, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        #3;
        reset = 1'b1;
        step();
        chk_state("rel2", 3'd1, 1'b0, 1'b0, 1'b0);
        chk("rel2_bajo", 32'(bus.bajo_out), 32'd1);
        chk("rel2_alto", 32'(bus.alto_out), 32'd6);
        step();
        chk_state("idle3", 3'd2, 1'b1, 1'b0, 1'b0);

        // 5: error with init, sticky
        bus.empty_fifos = 8'hFB;
        step();
        chk_state("act3", 3'd3, 1'b0, 1'b1, 1'b0);
        bus.error_fifos = 8'h20; bus.init = 1'b1;
        #1;
        chk("to_err_sig", 32'(bus.sig_estado), 32'd4);
        step();
        chk_state("err", 3'd4, 1'b0, 1'b0, 1'b1);
        chk("err_id", 32'(bus.error_id), 32'h20);
        bus.error_fifos = 8'h01; bus.init = 1'b0;
        step();
        chk_state("err_hold", 3'd4, 1'b0, 1'b0, 1'b1);
        chk("err_id_hold", 32'(bus.error_id), 32'h20);
        bus.init = 1'b1; bus.error_fifos = 8'h00;
        step();
        chk_state("err_init", 3'd4, 1'b0, 1'b0, 1'b1);
        chk("err_sig", 32'(bus.sig_estado), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("err_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
